// File: rtl/cordic_cos_sequencer.sv
// cordic_cos_sequencer: single-precision operand front end for the iterative CORDIC cosine core.
// Answers NaN/Inf/zero/subnormal operands locally and runs normal ones on the core under a watchdog.
module cordic_cos_sequencer #(
  parameter int TIMEOUT = 64,
  parameter logic [31:0] QNAN = 32'h7FC00000,
  parameter logic [31:0] ONE = 32'h3F800000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        core_start,
  output logic [31:0] core_x,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_flags
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [31:0] op;
  logic [WW-1:0] wd;
  logic e_max, e_zero, m_zero;
  always_comb begin
    e_max = &op[30:23];
    e_zero = ~|op[30:23];
    m_zero = ~|op[22:0];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op <= '0;
      wd <= '0;
      in_ready <= 1'b0;
      core_start <= 1'b0;
      core_x <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op <= in_data;
            in_ready <= 1'b0;
            out_flags <= '0;
            state <= CHECK;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CHECK: begin
          out_flags <= {1'b0, e_max & ~m_zero, e_max & m_zero, e_zero & m_zero, e_zero & ~m_zero};
          if (e_max || e_zero) begin
            out_data <= e_max ? QNAN : ONE;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            core_x <= op;
            core_start <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          wd <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done wins over the terminal count, so a result on the last cycle is kept
          if (core_done) begin
            out_data <= core_result;
            out_valid <= 1'b1;
            state <= DONE;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            out_data <= QNAN;
            out_flags[4] <= 1'b1;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_cos_sequencer.sv
// tb_cordic_cos_sequencer: directed vectors for the CORDIC cosine front end.
module tb_cordic_cos_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic core_done = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] core_result = '0;
  logic in_ready, core_start, out_valid;
  logic [31:0] core_x, out_data;
  logic [4:0] out_flags;
  int vectors = 0;
  int miscompares = 0;
  int starts = 0;

  cordic_cos_sequencer #(.TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_start(core_start), .core_x(core_x), .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (core_start) starts++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 32'hDEADBEEF;
    check("in_ready_drop", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!core_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("core_start_seen", {31'b0, core_start}, 32'd1);
  endtask

  task automatic pulse_done(input logic [31:0] r);
    core_done = 1'b1;
    core_result = r;
    @(negedge clk);
    core_done = 1'b0;
    core_result = 32'hBADC0FFE;
  endtask

  task automatic recv(input string tag, input logic [31:0] d, input logic [4:0] f);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_flags"}, {27'b0, out_flags}, {27'b0, f});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_vdrop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic special(input string tag, input logic [31:0] op, input logic [31:0] d, input logic [4:0] f);
    int s0 = starts;
    send(op);
    check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_lat2"}, {31'b0, out_valid}, 32'd1);
    recv(tag, d, f);
    check({tag, "_nostart"}, starts - s0, 32'd0);
  endtask

  task automatic normal(input string tag, input logic [31:0] op, input logic [31:0] r);
    int s0 = starts;
    send(op);
    wait_start();
    check({tag, "_core_x"}, core_x, op);
    repeat (4) @(negedge clk);
    check({tag, "_core_x_hold"}, core_x, op);
    pulse_done(r);
    recv(tag, r, 5'b00000);
    check({tag, "_starts"}, starts - s0, 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] held;
    #2;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_flags", {27'b0, out_flags}, 32'd0);
    check("rst_core_x", core_x, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, in_ready}, 32'd1);

    normal("n32", 32'h42000000, 32'h3F5A2B1C);
    special("inf", 32'h7F800000, 32'h7FC00000, 5'b00100);
    special("nan", 32'h7FFFFFFF, 32'h7FC00000, 5'b01000);
    special("subn", 32'h0020AAC8, 32'h3F800000, 5'b00001);
    special("nzero", 32'h80000000, 32'h3F800000, 5'b00010);

    // timeout: core never answers
    send(32'hE97E1C91);
    wait_start();
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, 32'd65);
    repeat (3) @(negedge clk);
    pulse_done(32'h12345678);
    check("to_late_data", out_data, 32'h7FC00000);
    check("to_late_ready", {31'b0, in_ready}, 32'd0);
    recv("to", 32'h7FC00000, 5'b10000);
    pulse_done(32'h12345678);
    check("to_idle_valid", {31'b0, out_valid}, 32'd0);
    check("to_idle_ready", {31'b0, in_ready}, 32'd1);

    // backpressure with a competing operand offered
    send(32'h7F800000);
    @(negedge clk);
    held = out_data;
    in_valid = 1'b1;
    in_data = 32'h42000000;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'h7FC00000);
      check("bp_hold", out_data, held);
      check("bp_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    recv("bp", 32'h7FC00000, 5'b00100);
    repeat (3) @(negedge clk);
    check("bp_no_extra", {31'b0, out_valid}, 32'd0);

    // reset in the middle of WAIT
    send(32'h42000000);
    wait_start();
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_start", {31'b0, core_start}, 32'd0);
    check("mid_rst_core_x", core_x, 32'd0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_done(32'h3F000000);
    repeat (3) @(negedge clk);
    check("mid_rst_late", {31'b0, out_valid}, 32'd0);
    normal("after_rst", 32'h40490FDB, 32'hBF800000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
